rcs80_seq: RTL and testbench

Multi-cycle unsigned/two's-complement subtractor computing D = A − B − Bin over WIDTH bits. It uses one SLICE-bit ripple-borrow datapath, processing one slice per cycle, LSB slice first. It is the subtraction counterpart to the team's ripple-carry adders, for use where area matters more than latency. Operands enter, and results leave, through valid/ready handshakes.

---
 rtl/rcs80_seq.sv | 110 +++++++++++
 tb/tb_rcs80_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcs80_seq.sv
// Multi-cycle subtractor D = A - B - Bin, one SLICE-bit ripple-borrow slice per cycle,
// LSB slice first, with valid/ready handshakes on operands and results.
module rcs80_seq #(
  parameter int WIDTH = 80,
  parameter int SLICE = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic             r_borrow;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_in_ready;
  logic [SLICE-1:0] w_as;
  logic [SLICE-1:0] w_bs;
  logic [SLICE:0]   w_sum;
  logic             w_borrow;
  logic [WIDTH-1:0] w_d_next;
  logic             w_ovf;

  assign w_in_ready = (r_state == IDLE) && !rst;

  // Slice computed as A + ~B + ~borrow; the outgoing borrow is the inverted carry.
  always_comb begin
    w_as     = r_a[r_k*SLICE +: SLICE];
    w_bs     = r_b[r_k*SLICE +: SLICE];
    w_sum    = {1'b0, w_as} + {1'b0, ~w_bs} + {{SLICE{1'b0}}, ~r_borrow};
    w_borrow = ~w_sum[SLICE];
    w_d_next = r_d;
    w_d_next[r_k*SLICE +: SLICE] = w_sum[SLICE-1:0];
    w_ovf    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_next[WIDTH-1] != r_a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && w_in_ready) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_k      <= '0;
            r_d      <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_d      <= w_d_next;
          r_borrow <= w_borrow;
          r_k      <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_bout  <= w_borrow;
            r_zero  <= (w_d_next == '0);
            r_ovf   <= w_ovf;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign D         = r_d;
  assign Bout      = r_bout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_rcs80_seq.sv
// Scoreboard bench for rcs80_seq: driver pushes reference results on accept,
// monitor pops and compares on each result handshake.
module tb_rcs80_seq;

  localparam int WIDTH  = 80;
  localparam int SLICE  = 40;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] D;
  logic             Bout, zero, ovf;

  rcs80_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;
    int               acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;   // 0 random out_ready, 1 hold low, 2 force high

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input int acc);
    exp_t e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    e.d    = full[WIDTH-1:0];
    e.bout = full[WIDTH];
    e.zero = (e.d == '0);
    e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
    e.acc  = acc;
    return e;
  endfunction

  // One driver cycle: inputs change on the falling edge; an accept is recorded if
  // the following rising edge will see in_valid & in_ready.
  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, output logic accepted);
    @(negedge clk);
    in_valid = v; A = a; B = b; Bin = bin;
    #1;
    accepted = v && in_ready;
    if (accepted) sbq.push_back(model(a, b, bin, cyc));
  endtask

  function automatic logic [WIDTH-1:0] rnd80();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) drive(1'b1, a, b, bin, acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
    end
    drive(1'b0, rnd80(), rnd80(), 1'b0, acc);
  endtask

  // Monitor
  logic             prev_ov = 1'b0;
  logic             prev_hs = 1'b0;
  logic [WIDTH-1:0] h_d;
  logic             h_b, h_z, h_o;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_ov = 1'b0; prev_hs = 1'b0;
      end else begin
        out_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (prev_hs) begin
          chk("ov_low_after_hs", WIDTH'(out_valid), WIDTH'(1'b0));
          chk("ready_after_hs", WIDTH'(in_ready), WIDTH'(1'b1));
        end
        if (out_valid) begin
          chk("in_ready_in_done", WIDTH'(in_ready), WIDTH'(1'b0));
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (empty scoreboard)");
          end else if (!prev_ov) begin
            chk("latency", WIDTH'(cyc - sbq[0].acc), WIDTH'(NSLICE + 1));
          end else begin
            chk("hold_D", D, h_d);
            chk("hold_flags", WIDTH'({Bout, zero, ovf}), WIDTH'({h_b, h_z, h_o}));
          end
          h_d = D; h_b = Bout; h_z = zero; h_o = ovf;
          if (out_ready && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("D", D, e.d);
            chk("Bout", WIDTH'(Bout), WIDTH'(e.bout));
            chk("zero", WIDTH'(zero), WIDTH'(e.zero));
            chk("ovf", WIDTH'(ovf), WIDTH'(e.ovf));
          end
        end
        prev_ov = out_valid;
        prev_hs = out_valid && out_ready;
      end
    end
  end

  initial begin
    logic acc;
    logic [WIDTH-1:0] a, b;
    int n;

    // reset state
    repeat (3) drive(1'b0, '0, '0, 1'b0, acc);
    chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
    chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("rst_outs", WIDTH'({Bout, zero, ovf}), WIDTH'(3'b000));
    chk("rst_D", D, '0);
    @(negedge clk); rst = 1'b0; #1;
    chk("in_ready_after_rst", WIDTH'(in_ready), WIDTH'(1'b1));

    // directed cases
    do_op(80'd5, 80'd3, 1'b0);
    do_op(80'd0, 80'd1, 1'b0);
    do_op(80'h1234, 80'h1234, 1'b1);
    do_op(80'h1234, 80'h1234, 1'b0);
    do_op(80'h00_0000_0100_0000_0000, 80'd1, 1'b0);
    do_op(80'h8000_0000_0000_0000_0000, 80'd1, 1'b0);
    do_op({WIDTH{1'b1}}, '0, 1'b1);

    // backpressure in DONE with junk on the operand port
    repeat (8) drive(1'b0, '0, '0, 1'b0, acc);
    mode = 1;
    do_op(80'd5, 80'd3, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin drive(1'b0, '0, '0, 1'b0, acc); n++; end
    chk("bp_reached_done", WIDTH'(out_valid), WIDTH'(1'b1));
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), rnd80(), rnd80(), 1'($urandom), acc);
      chk("bp_in_ready_low", WIDTH'(in_ready), WIDTH'(1'b0));
    end
    mode = 2;
    drive(1'b0, '0, '0, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b0, acc);
    chk("bp_release_ov", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("bp_release_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    mode = 0;

    // reset during CALC at k=1
    mode = 1;
    repeat (4) drive(1'b0, '0, '0, 1'b0, acc);
    do_op(80'd5, 80'd3, 1'b0);   // accept edge, then one slice edge already passed
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
    chk("midrst_D", D, '0);
    chk("midrst_flags", WIDTH'({Bout, zero, ovf}), WIDTH'(3'b000));
    chk("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    mode = 0;
    do_op(80'd5, 80'd3, 1'b0);

    // randomized operations with random gaps
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = rnd80(); b = rnd80(); end
        1: begin a = rnd80(); b = a; end
        2: begin a = WIDTH'($urandom_range(0, 7)); b = WIDTH'($urandom_range(0, 7)); end
        default: begin
          a = rnd80(); b = rnd80();
          a[WIDTH-1] = 1'($urandom); b[WIDTH-1] = ~a[WIDTH-1];
          a[SLICE-1:0] = '0;
        end
      endcase
      do_op(a, b, 1'($urandom));
      repeat ($urandom_range(0, 2)) drive(1'b0, rnd80(), rnd80(), 1'b0, acc);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin drive(1'b0, '0, '0, 1'b0, acc); n++; end
    chk("scoreboard_drained", WIDTH'(sbq.size()), '0);
    repeat (3) drive(1'b0, '0, '0, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
